time_counter: RTL and testbench

- Time-of-day core holding hours, minutes and seconds, sitting directly downstream of time_set.
- In RUN mode it counts on 1 Hz strobes with carry propagation. In SET mode it freezes and adjusts the field selected by time_set's one-hot enables, driven by increment/decrement pulses.
- Binary and BCD time values feed the display driver; a day-rollover strobe feeds the alarm/date logic.

---
 rtl/time_counter.sv | 110 +++++++++++
 tb/tb_time_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Time-of-day core: hours/minutes/seconds counted on 1 Hz strobes in RUN, adjusted field-by-field in SET.
// Binary fields are registered; BCD views are decoded combinationally from them.
module time_counter #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int SEC_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       set_time_en,
  input  logic       set_hour_en,
  input  logic       set_minute_en,
  input  logic       set_second_en,
  input  logic       set_inc,
  input  logic       set_dec,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       day_tick,
  output logic       setting
);

  localparam logic [4:0] L_HOUR_MAX = 5'(HOUR_MAX);
  localparam logic [5:0] L_MIN_MAX  = 6'(MIN_MAX);
  localparam logic [5:0] L_SEC_MAX  = 6'(SEC_MAX);

  typedef enum logic {ST_RUN, ST_SET} state_t;

  state_t     r_state;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_day_tick;

  logic       w_hour_max, w_min_max, w_sec_max;
  logic [4:0] w_hour_up, w_hour_dn;
  logic [5:0] w_min_up, w_min_dn, w_sec_up, w_sec_dn;
  logic       w_adj, w_sel_hour, w_sel_min, w_sel_sec;

  function automatic logic [7:0] f_to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  always_comb begin
    w_hour_max = (r_hour == L_HOUR_MAX);
    w_min_max  = (r_min == L_MIN_MAX);
    w_sec_max  = (r_sec == L_SEC_MAX);
    w_hour_up  = w_hour_max ? 5'd0 : r_hour + 5'd1;
    w_min_up   = w_min_max ? 6'd0 : r_min + 6'd1;
    w_sec_up   = w_sec_max ? 6'd0 : r_sec + 6'd1;
    w_hour_dn  = (r_hour == 5'd0) ? L_HOUR_MAX : r_hour - 5'd1;
    w_min_dn   = (r_min == 6'd0) ? L_MIN_MAX : r_min - 6'd1;
    w_sec_dn   = (r_sec == 6'd0) ? L_SEC_MAX : r_sec - 6'd1;
    // Simultaneous inc and dec cancel; hour beats minute beats second.
    w_adj      = set_inc ^ set_dec;
    w_sel_hour = set_hour_en;
    w_sel_min  = ~set_hour_en & set_minute_en;
    w_sel_sec  = ~set_hour_en & ~set_minute_en & set_second_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_hour     <= 5'd0;
      r_min      <= 6'd0;
      r_sec      <= 6'd0;
      r_day_tick <= 1'b0;
    end else begin
      r_day_tick <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (sec_tick) begin
            r_sec <= w_sec_up;
            if (w_sec_max) begin
              r_min <= w_min_up;
              if (w_min_max) begin
                r_hour <= w_hour_up;
                if (w_hour_max) r_day_tick <= 1'b1;
              end
            end
          end
          if (set_time_en) r_state <= ST_SET;
        end
        ST_SET: begin
          if (w_adj) begin
            if (w_sel_hour) r_hour <= set_inc ? w_hour_up : w_hour_dn;
            if (w_sel_min)  r_min  <= set_inc ? w_min_up  : w_min_dn;
            if (w_sel_sec)  r_sec  <= set_inc ? w_sec_up  : w_sec_dn;
          end
          if (!set_time_en) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign hour       = r_hour;
  assign minute     = r_min;
  assign second     = r_sec;
  assign day_tick   = r_day_tick;
  assign setting    = (r_state == ST_SET);
  assign hour_bcd   = f_to_bcd({1'b0, r_hour});
  assign minute_bcd = f_to_bcd(r_min);
  assign second_bcd = f_to_bcd(r_sec);

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios plus random stimulus against a seconds-of-day model.
module tb_time_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0, set_time_en = 1'b0;
  logic       set_hour_en = 1'b0, set_minute_en = 1'b0, set_second_en = 1'b0;
  logic       set_inc = 1'b0, set_dec = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [7:0] hour_bcd, minute_bcd, second_bcd;
  logic       day_tick, setting;

  int total = 0;
  int bad = 0;
  int mh = 0, mm = 0, ms = 0;
  bit mset = 0, mday = 0;

  time_counter dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .set_time_en(set_time_en),
    .set_hour_en(set_hour_en), .set_minute_en(set_minute_en), .set_second_en(set_second_en),
    .set_inc(set_inc), .set_dec(set_dec), .hour(hour), .minute(minute), .second(second),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .day_tick(day_tick), .setting(setting)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, sample 1 time unit later.
  task automatic step(input bit tk, se, he, me, sce, inc, dec);
    int t;
    sec_tick = tk; set_time_en = se; set_hour_en = he; set_minute_en = me;
    set_second_en = sce; set_inc = inc; set_dec = dec;
    @(posedge clk);
    mday = 0;
    if (!mset) begin
      if (tk) begin
        t = mh * 3600 + mm * 60 + ms + 1;
        if (t == 86400) begin t = 0; mday = 1; end
        mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
      end
    end else if (inc != dec) begin
      if (he)       mh = inc ? (mh + 1) % 24 : (mh + 23) % 24;
      else if (me)  mm = inc ? (mm + 1) % 60 : (mm + 59) % 60;
      else if (sce) ms = inc ? (ms + 1) % 60 : (ms + 59) % 60;
    end
    mset = se;
    #1;
  endtask

  task automatic goto_time(input int h, m, s);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64 && mh != h; i++) step(0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 64 && mm != m; i++) step(0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 64 && ms != s; i++) step(0, 1, 0, 0, 1, 1, 0);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if ({hour, minute, second} !== 17'd0) begin
      bad++; $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", hour, minute, second);
    end
    total++;
    if ({hour_bcd, minute_bcd, second_bcd, day_tick, setting} !== 26'd0) begin
      bad++; $display("FAIL reset_misc got=%h/%h/%h dt=%b set=%b exp=00/00/00 dt=0 set=0",
                      hour_bcd, minute_bcd, second_bcd, day_tick, setting);
    end
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({hour, minute, second, setting} !== 18'd0) begin
      bad++; $display("FAIL post_reset_idle got=%0d:%0d:%0d set=%b exp=0:0:0 set=0",
                      hour, minute, second, setting);
    end
  endtask

  task automatic test_count_61;
    bit saw_day = 0;
    repeat (61) begin
      step(1, 0, 0, 0, 0, 0, 0);
      if (day_tick) saw_day = 1;
    end
    total++;
    if (hour !== 5'd0 || minute !== 6'd1 || second !== 6'd1) begin
      bad++; $display("FAIL count61_time got=%0d:%0d:%0d exp=0:1:1", hour, minute, second);
    end
    total++;
    if (second_bcd !== 8'h01) begin
      bad++; $display("FAIL count61_sec_bcd got=%h exp=01", second_bcd);
    end
    total++;
    if (saw_day !== 1'b0) begin
      bad++; $display("FAIL count61_day_tick got=1 exp=0");
    end
  endtask

  task automatic test_day_rollover;
    goto_time(23, 59, 58);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd59 || day_tick !== 1'b0) begin
      bad++; $display("FAIL roll_first got=%0d:%0d:%0d dt=%b exp=23:59:59 dt=0",
                      hour, minute, second, day_tick);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    total++;
    if ({hour, minute, second} !== 17'd0 || day_tick !== 1'b1) begin
      bad++; $display("FAIL roll_wrap got=%0d:%0d:%0d dt=%b exp=0:0:0 dt=1",
                      hour, minute, second, day_tick);
    end
    total++;
    if (hour_bcd !== 8'h00) begin
      bad++; $display("FAIL roll_hour_bcd got=%h exp=00", hour_bcd);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (day_tick !== 1'b0) begin
      bad++; $display("FAIL roll_day_tick_width got=%b exp=0", day_tick);
    end
  endtask

  task automatic test_minute_wrap;
    goto_time(5, 59, 10);
    step(0, 1, 0, 1, 0, 1, 0);
    total++;
    if (minute !== 6'd0 || hour !== 5'd5 || second !== 6'd10) begin
      bad++; $display("FAIL min_inc_wrap got=%0d:%0d:%0d exp=5:0:10", hour, minute, second);
    end
    step(0, 1, 0, 1, 0, 0, 1);
    total++;
    if (minute !== 6'd59 || hour !== 5'd5 || minute_bcd !== 8'h59) begin
      bad++; $display("FAIL min_dec_wrap got=%0d:%0d bcd=%h exp=5:59 bcd=59", hour, minute, minute_bcd);
    end
  endtask

  task automatic test_hour_dec_freeze;
    goto_time(0, 30, 20);
    step(1, 1, 1, 0, 0, 0, 1);
    total++;
    if (hour !== 5'd23 || hour_bcd !== 8'h23 || day_tick !== 1'b0) begin
      bad++; $display("FAIL hour_dec_wrap got=%0d bcd=%h dt=%b exp=23 bcd=23 dt=0", hour, hour_bcd, day_tick);
    end
    repeat (5) step(1, 1, 0, 0, 0, 0, 0);
    total++;
    if (second !== 6'd20 || minute !== 6'd30 || hour !== 5'd23 || setting !== 1'b1) begin
      bad++; $display("FAIL set_freeze got=%0d:%0d:%0d set=%b exp=23:30:20 set=1",
                      hour, minute, second, setting);
    end
  endtask

  task automatic test_priority;
    goto_time(7, 8, 9);
    step(0, 1, 1, 0, 1, 1, 0);
    total++;
    if (hour !== 5'd8 || minute !== 6'd8 || second !== 6'd9) begin
      bad++; $display("FAIL prio_hour_over_sec got=%0d:%0d:%0d exp=8:8:9", hour, minute, second);
    end
    step(0, 1, 1, 1, 1, 1, 1);
    total++;
    if (hour !== 5'd8 || minute !== 6'd8 || second !== 6'd9) begin
      bad++; $display("FAIL inc_dec_cancel got=%0d:%0d:%0d exp=8:8:9", hour, minute, second);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    total++;
    if (hour !== 5'd8 || second !== 6'd10 || setting !== 1'b1) begin
      bad++; $display("FAIL entry_cycle got=%0d:..:%0d set=%b exp=8:..:10 set=1", hour, second, setting);
    end
  endtask

  task automatic test_random;
    bit se = 0;
    logic [18:0] exp_v;
    logic [23:0] exp_b;
    goto_time(23, 59, 40);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) se = ~se;
      step(1'($urandom_range(0, 3) != 0), se, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      exp_v = {5'(mh), 6'(mm), 6'(ms), mday, mset};
      exp_b = {bcd(mh), bcd(mm), bcd(ms)};
      total++;
      if ({hour, minute, second, day_tick, setting} !== exp_v) begin
        bad++; $display("FAIL rand_state i=%0d got=%0d:%0d:%0d dt=%b set=%b exp=%0d:%0d:%0d dt=%b set=%b",
                        i, hour, minute, second, day_tick, setting, mh, mm, ms, mday, mset);
      end
      total++;
      if ({hour_bcd, minute_bcd, second_bcd} !== exp_b) begin
        bad++; $display("FAIL rand_bcd i=%0d got=%h exp=%h", i, {hour_bcd, minute_bcd, second_bcd}, exp_b);
      end
    end
  endtask

  task automatic test_async_reset;
    goto_time(12, 34, 56);
    total++;
    if (hour !== 5'd12 || minute !== 6'd34 || second !== 6'd56 || setting !== 1'b1) begin
      bad++; $display("FAIL preload_12_34_56 got=%0d:%0d:%0d set=%b exp=12:34:56 set=1",
                      hour, minute, second, setting);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({hour, minute, second, hour_bcd, minute_bcd, second_bcd, day_tick, setting} !== 43'd0) begin
      bad++; $display("FAIL async_reset got=%0d:%0d:%0d bcd=%h/%h/%h dt=%b set=%b exp=all zero",
                      hour, minute, second, hour_bcd, minute_bcd, second_bcd, day_tick, setting);
    end
    sec_tick = 0; set_time_en = 0; set_hour_en = 0; set_minute_en = 0;
    set_second_en = 0; set_inc = 0; set_dec = 0;
    mh = 0; mm = 0; ms = 0; mset = 0; mday = 0;
    #2 rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (hour !== 5'd0 || minute !== 6'd0 || second !== 6'd1 || setting !== 1'b0) begin
      bad++; $display("FAIL after_reset_tick got=%0d:%0d:%0d set=%b exp=0:0:1 set=0",
                      hour, minute, second, setting);
    end
  endtask

  initial begin
    test_reset;
    test_count_61;
    test_day_rollover;
    test_minute_wrap;
    test_hour_dec_freeze;
    test_priority;
    test_random;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
